product_bcd_conv: RTL
=====================

Name: product_bcd_conv

Overview:
- Sequential binary-to-BCD converter using double-dabble (shift-add-3), one bit per clock.
- Sits directly downstream of the 4x4 combinational multiplier and consumes its 8-bit product (0..225).
- Produces three BCD digits for the board's 7-segment display path.
- Start/busy/done handshake; the result is held stable between conversions.

Parameters:
- W, 8, binary input width; sets the number of shift iterations.
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^W - 1.
- REFRESH_DIV, 100000, clk cycles per displayed digit; used only with SEVSEG_MUX_EN (1 ms at 100 MHz).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion of bin; sampled only in IDLE.
- bin  input  W  binary value (multiplier product p); captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd is updated.
- bcd  output  4*DIGITS  result; digit 0 = ones at [3:0], tens at [7:4], hundreds at [11:8].
- an  output  4  active-low digit anodes; present only with SEVSEG_MUX_EN.
- seg  output  7  active-low segments {g..a}; present only with SEVSEG_MUX_EN.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, bcd=0, internal shift/scratch registers=0, iteration counter=0.
- Reset mid-conversion aborts immediately, with no done pulse and bcd cleared to 0.
- FSM states:
  - IDLE: on start=1, load shift register {bcd_scratch=0, bin}, load counter=W, set busy=1, go to CONV.
  - CONV: each cycle, every scratch digit >=5 gets +3, then {scratch, bin_shift} shifts left by 1 and the counter decrements.
  - CONV exit: the edge that performs the W-th shift writes bcd <= final scratch, sets done=1, busy=0, and returns to IDLE.
- Latency: start sampled at edge 0; bcd and done valid after edge W (8 cycles for W=8). Throughput is one conversion per W+1 cycles.
- done is high for exactly one cycle and clears on the next edge unless a new conversion completes.
- start while busy=1 is ignored, not queued; bin changes during CONV have no effect.
- start asserted in the cycle done=1 (state IDLE) is accepted, so back-to-back conversions run with no gap.
- bcd holds its last result until the next completion or rst; it never shows partial values.
- Arithmetic: add-3 is applied per 4-bit digit before each shift, and no digit ever exceeds 9 in the final result.
- Inputs >225 (max 255) are converted correctly; the block is not limited to the multiplier's range.

Optional Feature:
- Macro: PRODUCT_BCD_SEVSEG_MUX_EN.
- Defined:
  - Adds ports an and seg, a free-running refresh counter (0..REFRESH_DIV-1), and a 2-bit digit selector that advances on counter wrap.
  - Selector order is an=1110 (ones), 1101 (tens), 1011 (hundreds), 0111 (blank, seg=7'h7F).
  - Digits are decoded from the held bcd only, never from scratch.
  - Reset values: counter=0, selector=0, an=4'b1111, seg=7'h7F.
- Undefined: ports an and seg do not exist, and there is no counter or decode logic.

Decomposition:
- Package product_bcd_pkg:
  - FSM state encoding (IDLE, CONV).
  - Digit width constant 4.
  - 7-segment pattern constants for 0-9 and blank.
- Sub-module bcd_to_sevseg: combinational 4-bit BCD to 7-bit active-low segments, used only under the macro.

Test Plan:
- bin=40 (4'b1010*4'b0100), start pulse -> busy=1 for 8 cycles, done pulse at cycle 8, bcd=12'h040.
- bin=225 (15*15) -> bcd=12'h225; bin=0 -> bcd=12'h000; bin=255 -> bcd=12'h255; bcd stable between done pulses.
- start=1 held continuously with bin=40 then 225 changed at cycle 3 -> first result 12'h040, next conversion starts in the done cycle and yields 12'h225.
- start pulsed at cycle 4 of a conversion of 99 -> ignored, single done, bcd=12'h099.
- rst asserted at cycle 5 of a conversion of 225 -> busy=0, done never pulses, bcd=12'h000; a following start with 40 gives 12'h040.
- With macro, REFRESH_DIV=4, bcd=12'h225 -> an cycles 1110/1101/1011/0111 every 4 clks; seg shows 5, 2, 2, then blank (7'h7F).

Source files
------------

// File: rtl/product_bcd_pkg.sv
// product_bcd_pkg: shared FSM encoding, digit width and active-low 7-segment patterns
package product_bcd_pkg;
  typedef enum logic {IDLE, CONV} state_t;
  localparam int DIGIT_W = 4;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/bcd_to_sevseg.sv
// bcd_to_sevseg: 4-bit BCD digit to active-low {g..a} segments; non-decimal codes blank
module bcd_to_sevseg import product_bcd_pkg::*; (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/product_bcd_conv.sv
// product_bcd_conv: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define PRODUCT_BCD_SEVSEG_MUX_EN to add the multiplexed 7-segment driver (an/seg).
module product_bcd_conv import product_bcd_pkg::*; #(
  parameter int W = 8,
  parameter int DIGITS = 3
`ifdef PRODUCT_BCD_SEVSEG_MUX_EN
  , parameter int REFRESH_DIV = 100000
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [W-1:0]              bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd
`ifdef PRODUCT_BCD_SEVSEG_MUX_EN
  , output logic [3:0]              an
  , output logic [6:0]              seg
`endif
);
  localparam int BW = DIGIT_W * DIGITS;
  localparam int SW = BW + W;
  localparam int CW = $clog2(W + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sh_q, sh_d, nxt;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic done_q, done_d;
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++)
      adj[i*DIGIT_W +: DIGIT_W] = sh_q[W+i*DIGIT_W +: DIGIT_W] >= 4'd5 ?
        sh_q[W+i*DIGIT_W +: DIGIT_W] + 4'd3 : sh_q[W+i*DIGIT_W +: DIGIT_W];
    // scratch MSB is dropped: 10^DIGITS > 2^W-1 guarantees it is always zero
    nxt = {adj[BW-2:0], sh_q[W-1:0], 1'b0};
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    bcd_d = bcd_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = CONV;
        cnt_d = CW'(W);
        sh_d = {{BW{1'b0}}, bin};
      end
    end else begin
      sh_d = nxt;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        bcd_d = nxt[SW-1:W];
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      bcd_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q == CONV;
  assign done = done_q;
  assign bcd = bcd_q;
`ifdef PRODUCT_BCD_SEVSEG_MUX_EN
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  logic [RW-1:0] ref_q;
  logic [1:0] sel_q;
  logic [3:0] an_q, dig;
  logic [6:0] seg_q, seg_w;
  assign dig = 4'(bcd_q >> {sel_q, 2'b00});
  bcd_to_sevseg u_seg (.bcd_i(dig), .seg_o(seg_w));
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      sel_q <= '0;
      an_q <= 4'hF;
      seg_q <= SEG_BLANK;
    end else begin
      ref_q <= ref_q == RW'(REFRESH_DIV - 1) ? '0 : ref_q + RW'(1);
      if (ref_q == RW'(REFRESH_DIV - 1)) sel_q <= sel_q + 2'd1;
      an_q <= ~(4'b0001 << sel_q);
      seg_q <= (sel_q == 2'd3 || int'(sel_q) >= DIGITS) ? SEG_BLANK : seg_w;
    end
  end
  assign an = an_q;
  assign seg = seg_q;
`endif
endmodule
